// File: rtl/ball_slot_scheduler.sv
// rtl/ball_slot_scheduler.sv - ball slot pool with spawn/hit command sequencer
module ball_slot_scheduler #(
    parameter int  NUM_BALLS      = 8,
    parameter int  OBJECT_WIDTH_X = 8,
    parameter int  MAX_SIZE       = 3,
    parameter int  X_MAX          = 640,
    localparam int IDX_W          = $clog2(NUM_BALLS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_type,
    input  logic [IDX_W-1:0]        cmd_idx,
    input  logic [10:0]             cmd_x,
    input  logic [10:0]             cmd_y,
    input  logic [2:0]              cmd_size,
    input  logic                    cmd_dir,
    input  logic                    pos_we,
    input  logic [IDX_W-1:0]        pos_idx,
    input  logic [10:0]             pos_x,
    input  logic [10:0]             pos_y,
    output logic                    done,
    output logic [1:0]              status,
    output logic [NUM_BALLS-1:0]    slot_active,
    output logic [NUM_BALLS*11-1:0] slot_x,
    output logic [NUM_BALLS*11-1:0] slot_y,
    output logic [NUM_BALLS*3-1:0]  slot_size,
    output logic [NUM_BALLS-1:0]    slot_dir,
    output logic                    all_cleared
);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_NO_SLOT = 2'b01;
    localparam logic [1:0] ST_BAD_IDX = 2'b10;
    localparam logic [1:0] ST_POPPED  = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WRITE, S_DONE} state_t;

    state_t            state, state_next;
    logic [1:0]        status_next;
    logic              scan_hit;
    logic [IDX_W-1:0]  scan_idx;
    logic [IDX_W-1:0]  free_idx;
    logic              found;

    logic [10:0]       x_q    [NUM_BALLS];
    logic [10:0]       y_q    [NUM_BALLS];
    logic [2:0]        size_q [NUM_BALLS];

    logic              lat_type;
    logic [IDX_W-1:0]  lat_idx;
    logic [10:0]       lat_x;
    logic [10:0]       lat_y;
    logic [2:0]        lat_size;
    logic              lat_dir;
    logic              lat_pop;

    logic [2:0]        spawn_size;
    logic [11:0]       child_w, child_lim, child_sum, child_x;

    assign cmd_ready   = (state == S_IDLE);
    assign all_cleared = ~|slot_active;
    assign lat_pop     = lat_type && (lat_size == 3'd0);
    assign spawn_size  = (cmd_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : cmd_size;

    // Child B sits one child-width to the right of the parent, kept fully on screen
    always_comb begin
        child_w   = 12'(OBJECT_WIDTH_X) << (lat_size - 3'd1);
        child_lim = (child_w >= 12'(X_MAX)) ? 12'd0 : 12'(X_MAX) - child_w;
        child_sum = {1'b0, lat_x} + child_w;
        child_x   = (child_sum > child_lim) ? child_lim : child_sum;
    end

    always_comb begin
        slot_x    = '0;
        slot_y    = '0;
        slot_size = '0;
        for (int i = 0; i < NUM_BALLS; i++) begin
            slot_x[11*i +: 11]  = x_q[i];
            slot_y[11*i +: 11]  = y_q[i];
            slot_size[3*i +: 3] = size_q[i];
        end
    end

    always_comb begin
        state_next  = state;
        status_next = status;
        scan_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (!cmd_type) begin
                        state_next = S_SCAN;
                    end else if (!slot_active[cmd_idx]) begin
                        state_next  = S_DONE;
                        status_next = ST_BAD_IDX;
                    end else if (size_q[cmd_idx] == 3'd0) begin
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_SCAN;
                    end
                end
            end
            S_SCAN: begin
                scan_hit = !slot_active[scan_idx];
                if (scan_hit || scan_idx == IDX_W'(NUM_BALLS - 1)) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                state_next = S_DONE;
                if (lat_pop) begin
                    status_next = ST_POPPED;
                end else begin
                    status_next = found ? ST_OK : ST_NO_SLOT;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state       <= S_IDLE;
            scan_idx    <= '0;
            free_idx    <= '0;
            found       <= 1'b0;
            lat_type    <= 1'b0;
            lat_idx     <= '0;
            lat_x       <= '0;
            lat_y       <= '0;
            lat_size    <= '0;
            lat_dir     <= 1'b0;
            done        <= 1'b0;
            status      <= ST_OK;
            slot_active <= '0;
            slot_dir    <= '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= '0;
                size_q[i] <= '0;
            end
        end else begin
            state <= state_next;
            done  <= (state_next == S_DONE);
            if (state_next == S_DONE) begin
                status <= status_next;
            end

            if (state == S_IDLE && cmd_valid) begin
                lat_type <= cmd_type;
                lat_idx  <= cmd_idx;
                scan_idx <= '0;
                if (cmd_type) begin
                    lat_x    <= x_q[cmd_idx];
                    lat_y    <= y_q[cmd_idx];
                    lat_size <= size_q[cmd_idx];
                    lat_dir  <= 1'b0;
                end else begin
                    lat_x    <= cmd_x;
                    lat_y    <= cmd_y;
                    lat_size <= spawn_size;
                    lat_dir  <= cmd_dir;
                end
            end

            if (state == S_SCAN) begin
                if (state_next == S_WRITE) begin
                    found    <= scan_hit;
                    free_idx <= scan_idx;
                end else begin
                    scan_idx <= scan_idx + IDX_W'(1);
                end
            end

            if (pos_we && slot_active[pos_idx]) begin
                x_q[pos_idx] <= pos_x;
                y_q[pos_idx] <= pos_y;
            end

            // Placed after the position write so a same-slot WRITE takes priority
            if (state == S_WRITE) begin
                if (!lat_type) begin
                    if (found) begin
                        slot_active[free_idx] <= 1'b1;
                        x_q[free_idx]         <= lat_x;
                        y_q[free_idx]         <= lat_y;
                        size_q[free_idx]      <= lat_size;
                        slot_dir[free_idx]    <= lat_dir;
                    end
                end else if (lat_pop) begin
                    slot_active[lat_idx] <= 1'b0;
                    x_q[lat_idx]         <= '0;
                    y_q[lat_idx]         <= '0;
                    size_q[lat_idx]      <= '0;
                    slot_dir[lat_idx]    <= 1'b0;
                end else begin
                    x_q[lat_idx]      <= lat_x;
                    y_q[lat_idx]      <= lat_y;
                    size_q[lat_idx]   <= lat_size - 3'd1;
                    slot_dir[lat_idx] <= 1'b0;
                    if (found) begin
                        slot_active[free_idx] <= 1'b1;
                        x_q[free_idx]         <= child_x[10:0];
                        y_q[free_idx]         <= lat_y;
                        size_q[free_idx]      <= lat_size - 3'd1;
                        slot_dir[free_idx]    <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
